// File: rtl/spi_pkg.sv
// Shared types for the configurable SPI master: FSM state encoding and
// the per-transfer clock mode.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PORCH_F,
      SHIFT,
      PORCH_B,
      DONE
   } state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   // Slave-select index width; a single slave still needs a one-bit index.
   function automatic int ss_width(input int num_ss);
      return (num_ss > 1) ? $clog2(num_ss) : 1;
   endfunction

endpackage

// File: rtl/spi_mstr_cfg_if.sv
// Host command / SPI pin bundle for spi_mstr_cfg. The master modport is the
// SPI master itself; the slave modport is whatever drives and observes it.
interface spi_mstr_cfg_if import spi_pkg::*; #(
   parameter int WIDTH  = 16,
   parameter int NUM_SS = 1
) ();

   localparam int SSW = ss_width(NUM_SS);

   logic              wrt;
   logic [WIDTH-1:0]  cmd;
   logic [SSW-1:0]    ss_sel;
   logic              cpol;
   logic              cpha;
   logic              MISO;
   logic              SCLK;
   logic              MOSI;
   logic [NUM_SS-1:0] SS_n;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  data;

   modport master (
      input  wrt, cmd, ss_sel, cpol, cpha, MISO,
      output SCLK, MOSI, SS_n, busy, done, data
   );

   modport slave (
      output wrt, cmd, ss_sel, cpol, cpha, MISO,
      input  SCLK, MOSI, SS_n, busy, done, data
   );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK divider: a down-counter over one SCLK period that issues leading and
// trailing edge strobes and keeps the registered SCLK level in step with them.
module spi_clk_gen #(
   parameter int CLK_DIV = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic start_cpol,
   input  logic en,
   input  logic cpol,
   output logic sclk,
   output logic lead_stb,
   output logic trail_stb
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int H  = CLK_DIV / 2;

   logic [CW-1:0] cnt;

   // cnt runs D-1 .. 0 within a period; the first half keeps SCLK at idle.
   assign lead_stb  = en && (cnt == CW'(H));
   assign trail_stb = en && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else begin
         if (start)
            cnt <= CW'(CLK_DIV - 1);
         else if (en)
            cnt <= trail_stb ? CW'(CLK_DIV - 1) : cnt - 1'b1;

         if (start)
            sclk <= start_cpol;
         else if (lead_stb)
            sclk <= ~cpol;
         else if (trail_stb)
            sclk <= cpol;
      end
   end

endmodule

// File: rtl/spi_mstr_cfg.sv
// Configurable-mode SPI master: one WIDTH-bit full-duplex transfer per
// accepted wrt, framed by half-period porches on either side of the shift.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for wrt; MOSI low, selects high, SCLK at last cpol
//   PORCH_F | select asserted, first bit on MOSI, H cycles before SCLK
//   SHIFT   | WIDTH SCLK periods, sample/advance per cpha
//   PORCH_B | H cycles after the last edge, select still asserted
//   DONE    | single cycle: done pulse, data updated, selects released
module spi_mstr_cfg import spi_pkg::*; #(
   parameter int WIDTH   = 16,
   parameter int CLK_DIV = 32,
   parameter int NUM_SS  = 1
) (
   input logic            clk,
   input logic            rst_n,
   spi_mstr_cfg_if.master bus
);

   localparam int H   = CLK_DIV / 2;
   localparam int TW  = $clog2(CLK_DIV);
   localparam int BW  = $clog2(WIDTH + 1);
   localparam int SSW = ss_width(NUM_SS);

   state_t            state, nxt;
   spi_mode_t         mode;
   logic [WIDTH-1:0]  tx_sr, rx_sr, data_r;
   logic [BW-1:0]     bit_cnt;
   logic [TW-1:0]     tmr;
   logic              mosi_r;
   logic [NUM_SS-1:0] ss_n_r, ss_dec;
   logic              start, en, busy_c, done_c;
   logic              sclk, lead, trail;
   logic              tmr_zero, first_bit, last_bit, shift_stb, samp_stb;

   assign tmr_zero  = (tmr == '0);
   assign first_bit = (bit_cnt == BW'(WIDTH));
   assign last_bit  = (bit_cnt == BW'(1));

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_cpol (bus.cpol),
      .en         (en),
      .cpol       (mode.cpol),
      .sclk       (sclk),
      .lead_stb   (lead),
      .trail_stb  (trail)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.wrt)          nxt = PORCH_F;
         PORCH_F: if (tmr_zero)         nxt = SHIFT;
         SHIFT:   if (trail && last_bit) nxt = PORCH_B;
         PORCH_B: if (tmr_zero)         nxt = DONE;
         DONE:                          nxt = IDLE;
         default:                       nxt = IDLE;
      endcase
   end

   always_comb begin
      start     = (state == IDLE) && bus.wrt;
      en        = (state == SHIFT);
      busy_c    = (state != IDLE);
      done_c    = (state == DONE);
      // cpha=1 already has bit 0 on MOSI, so its first leading edge is idle.
      shift_stb = mode.cpha ? (lead && !first_bit) : (trail && !last_bit);
      samp_stb  = mode.cpha ? trail : lead;
   end

   // Out-of-range indices match no line, leaving every select high.
   always_comb begin
      ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (bus.ss_sel == SSW'(i)) ss_dec[i] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode    <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         data_r  <= '0;
         bit_cnt <= '0;
         tmr     <= '0;
         mosi_r  <= 1'b0;
         ss_n_r  <= '1;
      end else if (start) begin
         mode    <= '{cpol: bus.cpol, cpha: bus.cpha};
         tx_sr   <= {bus.cmd[WIDTH-2:0], 1'b0};
         mosi_r  <= bus.cmd[WIDTH-1];
         rx_sr   <= '0;
         bit_cnt <= BW'(WIDTH);
         tmr     <= TW'(H - 1);
         ss_n_r  <= ss_dec;
      end else begin
         if ((state == PORCH_F || state == PORCH_B) && !tmr_zero)
            tmr <= tmr - 1'b1;
         if (state == SHIFT && trail && last_bit)
            tmr <= TW'(H - 1);
         if (trail)
            bit_cnt <= bit_cnt - 1'b1;
         if (shift_stb) begin
            mosi_r <= tx_sr[WIDTH-1];
            tx_sr  <= {tx_sr[WIDTH-2:0], 1'b0};
         end
         if (samp_stb)
            rx_sr <= {rx_sr[WIDTH-2:0], bus.MISO};
         if (nxt == DONE) begin
            data_r <= rx_sr;
            ss_n_r <= '1;
            mosi_r <= 1'b0;
         end
      end
   end

   assign bus.SCLK = sclk;
   assign bus.MOSI = mosi_r;
   assign bus.SS_n = ss_n_r;
   assign bus.busy = busy_c;
   assign bus.done = done_c;
   assign bus.data = data_r;

endmodule

// File: tb/tb_spi_mstr_cfg.sv
// Bench for spi_mstr_cfg: a default instance and a small 8-bit/4-slave one,
// each driven against a behavioural SPI slave that follows the mode rules.
module tb_spi_mstr_cfg;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_mstr_cfg_if #(.WIDTH(16), .NUM_SS(1)) if0 ();
   spi_mstr_cfg_if #(.WIDTH(8),  .NUM_SS(4)) if1 ();

   spi_mstr_cfg #(.WIDTH(16), .CLK_DIV(32), .NUM_SS(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   spi_mstr_cfg #(.WIDTH(8),  .CLK_DIV(4),  .NUM_SS(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   function automatic int wid(input int i); return (i == 0) ? 16 : 8; endfunction
   function automatic int div(input int i); return (i == 0) ? 32 : 4; endfunction
   function automatic int nss(input int i); return (i == 0) ? 1 : 4;  endfunction

   // stimulus and slave configuration, written only by the main initial
   logic        wrt_d [2];
   logic [31:0] cmd_d [2];
   logic [2:0]  sel_d [2];
   logic        pol_d [2];
   logic        pha_d [2];
   logic        lb_m  [2];
   logic [31:0] sw_m  [2];
   logic [7:0]  exp_ssn [2];

   // normalised views of both instances
   logic        sclk_w [2], mosi_w [2], busy_w [2], done_w [2], miso_w [2];
   logic [7:0]  ssn_w  [2];
   logic [31:0] data_w [2];

   assign if0.wrt = wrt_d[0];  assign if0.cmd = cmd_d[0][15:0]; assign if0.ss_sel = sel_d[0][0:0];
   assign if0.cpol = pol_d[0]; assign if0.cpha = pha_d[0];      assign if0.MISO = miso_w[0];
   assign if1.wrt = wrt_d[1];  assign if1.cmd = cmd_d[1][7:0];  assign if1.ss_sel = sel_d[1][1:0];
   assign if1.cpol = pol_d[1]; assign if1.cpha = pha_d[1];      assign if1.MISO = miso_w[1];

   assign sclk_w[0] = if0.SCLK; assign mosi_w[0] = if0.MOSI; assign busy_w[0] = if0.busy;
   assign done_w[0] = if0.done; assign ssn_w[0] = {7'h7F, if0.SS_n}; assign data_w[0] = {16'h0, if0.data};
   assign sclk_w[1] = if1.SCLK; assign mosi_w[1] = if1.MOSI; assign busy_w[1] = if1.busy;
   assign done_w[1] = if1.done; assign ssn_w[1] = {4'hF, if1.SS_n}; assign data_w[1] = {24'h0, if1.data};

   // slave monitor state, written only by the negedge monitor
   int       tcyc;
   int       nsamp [2], nlead [2], last_lead [2], viol [2], done_cnt [2];
   bit [31:0] mosi_rx [2];
   bit       prev_sclk [2], prev_mosi [2], prev_busy [2], prev_done [2], pb_mosi [2];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   // Slave shifts its word out MSB first, one bit per master sample edge.
   always_comb begin
      logic [31:0] tmp;
      for (int i = 0; i < 2; i++) begin
         tmp = 32'h0;
         miso_w[i] = 1'b0;
         if (lb_m[i])
            miso_w[i] = mosi_w[i];
         else if (nsamp[i] < wid(i)) begin
            tmp = sw_m[i] >> (wid(i) - 1 - nsamp[i]);
            miso_w[i] = tmp[0];
         end
      end
   end

   always @(negedge clk) begin
      bit le, te, se, he;
      tcyc++;
      for (int i = 0; i < 2; i++) begin
         if (busy_w[i] && !prev_busy[i]) begin
            nsamp[i] = 0; nlead[i] = 0; mosi_rx[i] = 0; viol[i] = 0; done_cnt[i] = 0;
         end
         if (busy_w[i] && prev_busy[i]) begin
            le = (sclk_w[i] != prev_sclk[i]) && (sclk_w[i] == ~pol_d[i]);
            te = (sclk_w[i] != prev_sclk[i]) && (sclk_w[i] == pol_d[i]);
            se = pha_d[i] ? te : le;
            he = pha_d[i] ? le : te;
            if (se) begin
               mosi_rx[i] = {mosi_rx[i][30:0], prev_mosi[i]};
               nsamp[i]++;
               if (mosi_w[i] != prev_mosi[i]) viol[i]++;
            end
            if (mosi_w[i] != prev_mosi[i] && !se && !he && !done_w[i]) viol[i]++;
            if (le) begin
               if (nlead[i] > 0 && (tcyc - last_lead[i]) != div(i)) viol[i]++;
               last_lead[i] = tcyc;
               nlead[i]++;
            end
            if (!done_w[i] && ssn_w[i] != exp_ssn[i]) viol[i]++;
         end
         if (done_w[i]) done_cnt[i]++;
         if (done_w[i] && !prev_done[i]) pb_mosi[i] = prev_mosi[i];
         prev_sclk[i] = sclk_w[i]; prev_mosi[i] = mosi_w[i];
         prev_busy[i] = busy_w[i]; prev_done[i] = done_w[i];
      end
   end

   task automatic xfer(input int i, input logic [31:0] cmd, input int sel, input bit pol,
                       input bit pha, input bit lb, input logic [31:0] sw,
                       input bit pulses, input int abort_at);
      logic [31:0] mask, exp_data, data_before;
      int cyc, dchg, exp_lat;
      mask     = (i == 0) ? 32'hFFFF : 32'hFF;
      exp_data = (lb ? cmd : sw) & mask;
      exp_lat  = 1 + (wid(i) + 1) * div(i);
      @(posedge clk); #1;
      cmd_d[i] = cmd; sel_d[i] = sel[2:0]; pol_d[i] = pol; pha_d[i] = pha;
      lb_m[i] = lb; sw_m[i] = sw;
      exp_ssn[i] = 8'hFF;
      if (sel < nss(i)) exp_ssn[i][sel] = 1'b0;
      data_before = data_w[i];
      wrt_d[i] = 1'b1;
      @(posedge clk); #1;
      wrt_d[i] = 1'b0;
      cyc = 1; dchg = 0;
      while (!done_w[i] && cyc < exp_lat + 50) begin
         if (data_w[i] !== data_before) dchg++;
         if (cyc == abort_at) begin
            rst_n = 1'b0; #1;
            chk("abort_ssn",  32'(ssn_w[i]), 32'hFF);
            chk("abort_busy", 32'(busy_w[i]), 32'h0);
            chk("abort_sclk", 32'(sclk_w[i]), 32'h0);
            chk("abort_mosi", 32'(mosi_w[i]), 32'h0);
            chk("abort_data", data_w[i], 32'h0);
            repeat (2) @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (4) @(posedge clk); #1;
            chk("abort_no_done", 32'(done_cnt[i]), 32'h0);
            return;
         end
         wrt_d[i] = pulses && (cyc == 10 || cyc == 300);
         @(posedge clk); #1;
         cyc++;
      end
      wrt_d[i] = 1'b0;
      chk("latency",   32'(cyc), 32'(exp_lat));
      chk("done_hi",   32'(done_w[i]), 32'h1);
      chk("busy_done", 32'(busy_w[i]), 32'h1);
      chk("ssn_done",  32'(ssn_w[i]), 32'hFF);
      chk("data",      data_w[i], exp_data);
      chk("data_hold", 32'(dchg), 32'h0);
      @(posedge clk); #1;
      chk("idle_busy", 32'(busy_w[i]), 32'h0);
      chk("idle_done", 32'(done_w[i]), 32'h0);
      chk("idle_sclk", 32'(sclk_w[i]), 32'(pol));
      chk("idle_mosi", 32'(mosi_w[i]), 32'h0);
      chk("idle_ssn",  32'(ssn_w[i]), 32'hFF);
      chk("mosi_word", mosi_rx[i] & mask, cmd & mask);
      chk("nsamp",     32'(nsamp[i]), 32'(wid(i)));
      chk("nlead",     32'(nlead[i]), 32'(wid(i)));
      chk("mosi_pb",   32'(pb_mosi[i]), 32'(cmd[0]));
      chk("edge_viol", 32'(viol[i]), 32'h0);
      repeat (3) @(posedge clk); #1;
      chk("done_once", 32'(done_cnt[i]), 32'h1);
      chk("data_kept", data_w[i], exp_data);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wrt_d[i] = 1'b0; cmd_d[i] = '0; sel_d[i] = '0; pol_d[i] = 1'b0; pha_d[i] = 1'b0;
         lb_m[i] = 1'b1; sw_m[i] = '0; exp_ssn[i] = 8'hFF;
      end
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_sclk", 32'(sclk_w[i]), 32'h0);
         chk("rst_mosi", 32'(mosi_w[i]), 32'h0);
         chk("rst_ssn",  32'(ssn_w[i]), 32'hFF);
         chk("rst_busy", 32'(busy_w[i]), 32'h0);
         chk("rst_done", 32'(done_w[i]), 32'h0);
         chk("rst_data", data_w[i], 32'h0);
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      xfer(0, 32'hA5C3, 0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 0);   // mode 0 loopback
      xfer(0, 32'h0F0F, 0, 1'b1, 1'b1, 1'b0, 32'h3C5A, 1'b0, 0);   // mode 3 slave word
      xfer(1, 32'h81,   2, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 0);   // small instance, slave 2
      xfer(0, 32'h5A96, 0, 1'b0, 1'b1, 1'b1, 32'h0,    1'b1, 0);   // ignored wrt pulses
      xfer(0, 32'hFFFF, 0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 200); // reset abort
      xfer(0, 32'h1234, 0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 0);
      xfer(0, 32'h8001, 0, 1'b0, 1'b1, 1'b1, 32'h0,    1'b0, 0);   // mode 1
      xfer(0, 32'h8001, 0, 1'b1, 1'b0, 1'b1, 32'h0,    1'b0, 0);   // mode 2

      for (int k = 0; k < 4; k++)
         xfer(0, $urandom, int'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom, 1'b0, 0);
      for (int k = 0; k < 20; k++)
         xfer(1, $urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
